// File: rtl/ex_stage_pipe.sv
// Execute stage: operand forwarding, ALU, control-transfer targets and
// branch resolution feeding a valid-qualified output register. A taken
// control transfer raises REDIRECT and squashes the next KILL_CYCLES
// valid wrong-path instructions.
module ex_stage_pipe #(
    parameter int XLEN        = 32,
    parameter int KILL_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             EX_CLK,
    input  logic             EX_RST,
    input  logic             IN_VALID,
    input  logic             STALL,
    input  logic             FLUSH,
    input  logic [31:0]      IR,
    input  logic [XLEN-1:0]  PC_COUNT,
    input  logic [XLEN-1:0]  I_TYPE,
    input  logic [XLEN-1:0]  RS_1,
    input  logic [XLEN-1:0]  RS_2,
    input  logic [XLEN-1:0]  ALU_IN_1,
    input  logic [XLEN-1:0]  ALU_IN_2,
    input  logic             SRC_A_IS_RS,
    input  logic             SRC_B_IS_RS,
    input  logic [3:0]       ALU_FUN,
    input  logic [1:0]       FWD_SEL_1,
    input  logic [1:0]       FWD_SEL_2,
    input  logic [XLEN-1:0]  WB_DATA,
    output logic             OUT_VALID,
    output logic [XLEN-1:0]  ALU_RESULT,
    output logic [XLEN-1:0]  RS2_OUT,
    output logic [31:0]      IR_OUT,
    output logic [XLEN-1:0]  PC_OUT,
    output logic [XLEN-1:0]  JALR,
    output logic [XLEN-1:0]  BRANCH,
    output logic [XLEN-1:0]  JAL,
    output logic [1:0]       PC_SOURCE,
    output logic             REDIRECT,
    output logic [CNT_W-1:0] TAKEN_CNT
);

    localparam int SHW = $clog2(XLEN);
    // Counter must hold KILL_CYCLES; keep at least one bit when kills are disabled.
    localparam int KW = (KILL_CYCLES < 1) ? 1 : $clog2(KILL_CYCLES + 1);
    localparam logic [KW-1:0] KILL_INIT = KW'(KILL_CYCLES);

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic             r_out_valid;
    logic [XLEN-1:0]  r_alu_result;
    logic [XLEN-1:0]  r_rs2;
    logic [31:0]      r_ir;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_jalr;
    logic [XLEN-1:0]  r_branch;
    logic [XLEN-1:0]  r_jal;
    logic [1:0]       r_pc_source;
    logic [KW-1:0]    r_kill;
    logic [CNT_W-1:0] r_taken;

    logic [XLEN-1:0]  w_rs1_fwd;
    logic [XLEN-1:0]  w_rs2_fwd;
    logic [XLEN-1:0]  w_op_a;
    logic [XLEN-1:0]  w_op_b;
    logic [SHW-1:0]   w_shamt;
    logic [XLEN-1:0]  w_alu;
    logic [XLEN-1:0]  w_b_imm;
    logic [XLEN-1:0]  w_j_imm;
    logic             w_br_taken;
    logic [1:0]       w_pc_source;
    logic             w_live;

    // MEM forwarding uses the held ALU result even when its slot was dead.
    assign w_rs1_fwd = (FWD_SEL_1 == 2'b01) ? r_alu_result :
                       (FWD_SEL_1 == 2'b10) ? WB_DATA : RS_1;
    assign w_rs2_fwd = (FWD_SEL_2 == 2'b01) ? r_alu_result :
                       (FWD_SEL_2 == 2'b10) ? WB_DATA : RS_2;
    assign w_op_a    = SRC_A_IS_RS ? w_rs1_fwd : ALU_IN_1;
    assign w_op_b    = SRC_B_IS_RS ? w_rs2_fwd : ALU_IN_2;
    assign w_shamt   = w_op_b[SHW-1:0];

    assign w_b_imm = {{(XLEN-12){IR[31]}}, IR[7], IR[30:25], IR[11:8], 1'b0};
    assign w_j_imm = {{(XLEN-20){IR[31]}}, IR[19:12], IR[20], IR[30:21], 1'b0};

    assign w_live = IN_VALID && (r_kill == '0);

    // ALU operation select
    always_comb begin
        w_alu = '0;
        case (ALU_FUN)
            4'b0000: w_alu = w_op_a + w_op_b;
            4'b1000: w_alu = w_op_a - w_op_b;
            4'b0001: w_alu = w_op_a << w_shamt;
            4'b0010: w_alu = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            4'b0011: w_alu = {{(XLEN-1){1'b0}}, (w_op_a < w_op_b)};
            4'b0100: w_alu = w_op_a ^ w_op_b;
            4'b0101: w_alu = w_op_a >> w_shamt;
            4'b1101: w_alu = $unsigned($signed(w_op_a) >>> w_shamt);
            4'b0110: w_alu = w_op_a | w_op_b;
            4'b0111: w_alu = w_op_a & w_op_b;
            4'b1001: w_alu = w_op_a;
            default: w_alu = '0;
        endcase
    end

    // Branch condition on forwarded register values
    always_comb begin
        w_br_taken = 1'b0;
        case (IR[14:12])
            3'b000:  w_br_taken = (w_rs1_fwd == w_rs2_fwd);
            3'b001:  w_br_taken = (w_rs1_fwd != w_rs2_fwd);
            3'b100:  w_br_taken = ($signed(w_rs1_fwd) < $signed(w_rs2_fwd));
            3'b101:  w_br_taken = ($signed(w_rs1_fwd) >= $signed(w_rs2_fwd));
            3'b110:  w_br_taken = (w_rs1_fwd < w_rs2_fwd);
            3'b111:  w_br_taken = (w_rs1_fwd >= w_rs2_fwd);
            default: w_br_taken = 1'b0;
        endcase
    end

    // Next-PC source from the opcode
    always_comb begin
        w_pc_source = 2'd0;
        case (IR[6:0])
            OPC_JAL:    w_pc_source = 2'd3;
            OPC_JALR:   w_pc_source = 2'd1;
            OPC_BRANCH: w_pc_source = w_br_taken ? 2'd2 : 2'd0;
            default:    w_pc_source = 2'd0;
        endcase
    end

    // Datapath output registers; flush leaves them untouched since the slot is dead
    always_ff @(posedge EX_CLK) begin
        if (EX_RST) begin
            r_alu_result <= '0;
            r_rs2        <= '0;
            r_ir         <= '0;
            r_pc         <= '0;
            r_jalr       <= '0;
            r_branch     <= '0;
            r_jal        <= '0;
        end else if (!FLUSH && !STALL) begin
            r_alu_result <= w_alu;
            r_rs2        <= w_rs2_fwd;
            r_ir         <= IR;
            r_pc         <= PC_COUNT;
            r_jalr       <= (w_rs1_fwd + I_TYPE) & ~{{(XLEN-1){1'b0}}, 1'b1};
            r_branch     <= PC_COUNT + w_b_imm;
            r_jal        <= PC_COUNT + w_j_imm;
        end
    end

    // Validity, redirect source, wrong-path kill counter and taken counter
    always_ff @(posedge EX_CLK) begin
        if (EX_RST) begin
            r_out_valid <= 1'b0;
            r_pc_source <= 2'd0;
            r_kill      <= '0;
            r_taken     <= '0;
        end else if (FLUSH) begin
            r_out_valid <= 1'b0;
            r_kill      <= '0;
        end else if (!STALL) begin
            r_out_valid <= w_live;
            r_pc_source <= w_live ? w_pc_source : 2'd0;
            if (w_live && (w_pc_source != 2'd0)) begin
                r_kill  <= KILL_INIT;
                r_taken <= r_taken + CNT_W'(1);
            end else if (IN_VALID && (r_kill != '0)) begin
                r_kill  <= r_kill - KW'(1);
            end
        end
    end

    assign OUT_VALID  = r_out_valid;
    assign ALU_RESULT = r_alu_result;
    assign RS2_OUT    = r_rs2;
    assign IR_OUT     = r_ir;
    assign PC_OUT     = r_pc;
    assign JALR       = r_jalr;
    assign BRANCH     = r_branch;
    assign JAL        = r_jal;
    assign PC_SOURCE  = r_pc_source;
    assign REDIRECT   = r_out_valid && (r_pc_source != 2'd0);
    assign TAKEN_CNT  = r_taken;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Scoreboard bench for ex_stage_pipe: the stimulus side predicts each
// loaded slot from a behavioural model and queues it; the monitor checks
// every clock edge against the queue (load), held values (stall) or the
// dead-slot rules (flush).
module tb_ex_stage_pipe;

    localparam int KILL = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [31:0] ir = '0, pc = '0, itype = '0, rs1 = '0, rs2 = '0;
    logic [31:0] a1 = '0, a2 = '0, wb = '0;
    logic        sa = 1'b0, sb = 1'b0;
    logic [3:0]  fun = '0;
    logic [1:0]  f1 = '0, f2 = '0;

    logic        out_valid, redirect;
    logic [31:0] alu_result, rs2_out, ir_out, pc_out, jalr_o, branch_o, jal_o;
    logic [1:0]  pc_source;
    logic [15:0] taken_cnt;

    ex_stage_pipe #(.XLEN(32), .KILL_CYCLES(KILL), .CNT_W(16)) dut (
        .EX_CLK(clk), .EX_RST(rst), .IN_VALID(in_valid), .STALL(stall), .FLUSH(flush),
        .IR(ir), .PC_COUNT(pc), .I_TYPE(itype), .RS_1(rs1), .RS_2(rs2),
        .ALU_IN_1(a1), .ALU_IN_2(a2), .SRC_A_IS_RS(sa), .SRC_B_IS_RS(sb),
        .ALU_FUN(fun), .FWD_SEL_1(f1), .FWD_SEL_2(f2), .WB_DATA(wb),
        .OUT_VALID(out_valid), .ALU_RESULT(alu_result), .RS2_OUT(rs2_out),
        .IR_OUT(ir_out), .PC_OUT(pc_out), .JALR(jalr_o), .BRANCH(branch_o),
        .JAL(jal_o), .PC_SOURCE(pc_source), .REDIRECT(redirect), .TAKEN_CNT(taken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] alu, rs2, ir, pc, jalr, br, jal;
        logic [1:0]  src;
        logic [15:0] tc;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    // Model state
    logic [31:0] m_alu = '0;
    bit          m_alu_known = 1'b1;
    int          m_kill = 0;
    int          m_taken = 0;

    // Staged stimulus
    logic        d_v, d_st, d_fl, d_sa, d_sb;
    logic [31:0] d_ir, d_pc, d_it, d_rs1, d_rs2, d_a1, d_a2, d_wb;
    logic [3:0]  d_fun;
    logic [1:0]  d_f1, d_f2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic clr();
        d_v = 0; d_st = 0; d_fl = 0; d_sa = 0; d_sb = 0;
        d_ir = 32'h0000_0033; d_pc = 0; d_it = 0; d_rs1 = 0; d_rs2 = 0;
        d_a1 = 0; d_a2 = 0; d_wb = 0; d_fun = 0; d_f1 = 0; d_f2 = 0;
    endtask

    task automatic step();
        exp_t e;
        logic [31:0] v1, v2, a, b, res;
        logic [1:0]  src;
        logic        tk, live;
        int          bi, ji;
        @(negedge clk);
        rst = 0;
        in_valid = d_v; stall = d_st; flush = d_fl; ir = d_ir; pc = d_pc; itype = d_it;
        rs1 = d_rs1; rs2 = d_rs2; a1 = d_a1; a2 = d_a2; wb = d_wb; sa = d_sa; sb = d_sb;
        fun = d_fun; f1 = d_f1; f2 = d_f2;
        if (d_fl) begin
            m_kill = 0;
            m_alu_known = 0;
        end else if (!d_st) begin
            v1 = (d_f1 == 2'd1) ? m_alu : (d_f1 == 2'd2) ? d_wb : d_rs1;
            v2 = (d_f2 == 2'd1) ? m_alu : (d_f2 == 2'd2) ? d_wb : d_rs2;
            a = d_sa ? v1 : d_a1;
            b = d_sb ? v2 : d_a2;
            case (d_fun)
                4'd0:  res = a + b;
                4'd8:  res = a - b;
                4'd1:  res = a << (b % 32);
                4'd2:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                4'd3:  res = (a < b) ? 32'd1 : 32'd0;
                4'd4:  res = a ^ b;
                4'd5:  res = a >> (b % 32);
                4'd13: res = 32'($signed(a) >>> (b % 32));
                4'd6:  res = a | b;
                4'd7:  res = a & b;
                4'd9:  res = a;
                default: res = 32'd0;
            endcase
            bi = int'({d_ir[31], d_ir[7], d_ir[30:25], d_ir[11:8], 1'b0});
            if (d_ir[31]) bi -= 8192;
            ji = int'({d_ir[31], d_ir[19:12], d_ir[20], d_ir[30:21], 1'b0});
            if (d_ir[31]) ji -= (1 << 21);
            case (d_ir[14:12])
                3'd0: tk = (v1 == v2);
                3'd1: tk = (v1 != v2);
                3'd4: tk = ($signed(v1) < $signed(v2));
                3'd5: tk = ($signed(v1) >= $signed(v2));
                3'd6: tk = (v1 < v2);
                3'd7: tk = (v1 >= v2);
                default: tk = 0;
            endcase
            if (d_ir[6:0] == 7'h6F)      src = 2'd3;
            else if (d_ir[6:0] == 7'h67) src = 2'd1;
            else if (d_ir[6:0] == 7'h63) src = tk ? 2'd2 : 2'd0;
            else                         src = 2'd0;
            live = d_v && (m_kill == 0);
            if (live && src != 0) begin
                m_kill = KILL;
                m_taken++;
            end else if (d_v && m_kill > 0) begin
                m_kill--;
            end
            e.v = live;
            e.alu = res; e.rs2 = v2; e.ir = d_ir; e.pc = d_pc;
            e.jalr = (v1 + d_it) & 32'hFFFF_FFFE;
            e.br = d_pc + 32'(bi);
            e.jal = d_pc + 32'(ji);
            e.src = live ? src : 2'd0;
            e.tc = 16'(m_taken);
            m_alu = res;
            m_alu_known = 1;
            q.push_back(e);
        end
    endtask

    // Monitor: classify each edge from the inputs it sampled, check 1 time unit later
    logic        s_v, s_rd;
    logic [31:0] s_alu, s_rs2, s_ir, s_pc, s_jalr, s_br, s_jal;
    logic [1:0]  s_src;
    logic [15:0] s_tc;
    always @(posedge clk) begin
        automatic logic e_rst = rst;
        automatic logic e_fl = flush;
        automatic logic e_st = stall;
        exp_t e;
        #1;
        if (!e_rst) begin
            if (e_fl) begin
                chk("flush_valid", {31'd0, out_valid}, 32'd0);
                chk("flush_redirect", {31'd0, redirect}, 32'd0);
                chk("flush_taken_cnt", {16'd0, taken_cnt}, {16'd0, s_tc});
            end else if (e_st) begin
                chk("stall_valid", {31'd0, out_valid}, {31'd0, s_v});
                chk("stall_alu", alu_result, s_alu);
                chk("stall_rs2", rs2_out, s_rs2);
                chk("stall_ir", ir_out, s_ir);
                chk("stall_pc", pc_out, s_pc);
                chk("stall_jalr", jalr_o, s_jalr);
                chk("stall_branch", branch_o, s_br);
                chk("stall_jal", jal_o, s_jal);
                chk("stall_pc_source", {30'd0, pc_source}, {30'd0, s_src});
                chk("stall_redirect", {31'd0, redirect}, {31'd0, s_rd});
                chk("stall_taken_cnt", {16'd0, taken_cnt}, {16'd0, s_tc});
            end else if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_underflow act=load exp=none t=%0t", $time);
            end else begin
                e = q.pop_front();
                chk("out_valid", {31'd0, out_valid}, {31'd0, e.v});
                chk("alu_result", alu_result, e.alu);
                chk("rs2_out", rs2_out, e.rs2);
                chk("ir_out", ir_out, e.ir);
                chk("pc_out", pc_out, e.pc);
                chk("jalr", jalr_o, e.jalr);
                chk("branch", branch_o, e.br);
                chk("jal", jal_o, e.jal);
                chk("pc_source", {30'd0, pc_source}, {30'd0, e.src});
                chk("redirect", {31'd0, redirect}, {31'd0, (e.v && e.src != 0)});
                chk("taken_cnt", {16'd0, taken_cnt}, {16'd0, e.tc});
            end
        end
        s_v = out_valid; s_alu = alu_result; s_rs2 = rs2_out; s_ir = ir_out;
        s_pc = pc_out; s_jalr = jalr_o; s_br = branch_o; s_jal = jal_o;
        s_src = pc_source; s_rd = redirect; s_tc = taken_cnt;
    end

    initial begin
        logic [31:0] rv;
        logic [6:0]  opc;
        clr();
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_alu", alu_result, 32'd0);
        chk("rst_jalr", jalr_o, 32'd0);
        chk("rst_pc_source", {30'd0, pc_source}, 32'd0);
        chk("rst_taken_cnt", {16'd0, taken_cnt}, 32'd0);

        // add overflow wrap
        clr(); d_v = 1; d_a1 = 32'h7FFF_FFFF; d_a2 = 32'd1; step();
        // beq taken, then two killed and one live
        clr(); d_v = 1; d_ir = 32'h0020_8463; d_pc = 32'h100; d_rs1 = 5; d_rs2 = 5; step();
        for (int i = 0; i < 3; i++) begin clr(); d_v = 1; d_pc = 32'h104 + 4 * i; step(); end
        // jalr via WB forward
        clr(); d_v = 1; d_ir = 32'h0000_8067; d_rs1 = 32'h203; d_f1 = 2'b10; d_wb = 32'h1001; step();
        for (int i = 0; i < 3; i++) begin clr(); d_v = 1; step(); end
        // MEM forward back-to-back
        clr(); d_v = 1; d_a1 = 8; d_a2 = 8; step();
        clr(); d_v = 1; d_fun = 4'b1000; d_f1 = 2'b01; d_sa = 1; d_a2 = 4; step();
        // bubbles do not consume kill slots
        clr(); d_v = 1; d_ir = 32'h0020_8463; d_rs1 = 9; d_rs2 = 9; step();
        clr(); step();
        for (int i = 0; i < 3; i++) begin clr(); d_v = 1; step(); end
        // stall three cycles, then jal, flush over stall, live next
        for (int i = 0; i < 3; i++) begin clr(); d_v = 1; d_st = 1; d_a1 = 32'hDEAD; step(); end
        clr(); d_v = 1; d_ir = 32'h0100_006F; d_pc = 32'h2000; step();
        clr(); d_v = 1; d_st = 1; d_fl = 1; step();
        clr(); d_v = 1; step();
        // bltu vs blt on the same operands
        clr(); d_v = 1; d_ir = 32'h0000_6063; d_rs1 = 32'hFFFF_FFFF; d_rs2 = 1; step();
        clr(); d_v = 1; d_ir = 32'h0000_4063; d_rs1 = 32'hFFFF_FFFF; d_rs2 = 1; d_pc = 32'h40; step();

        for (int n = 0; n < 600; n++) begin
            clr();
            case ($urandom_range(0, 4))
                0: opc = 7'h6F;
                1: opc = 7'h67;
                2: opc = 7'h63;
                default: opc = 7'h33;
            endcase
            rv = $urandom();
            d_ir = {rv[31:7], opc};
            d_pc = $urandom(); d_it = $urandom(); d_wb = $urandom();
            d_rs1 = $urandom();
            d_rs2 = ($urandom_range(0, 3) == 0) ? d_rs1 : $urandom();
            d_a1 = $urandom(); d_a2 = $urandom();
            d_sa = 1'($urandom_range(0, 1)); d_sb = 1'($urandom_range(0, 1));
            d_fun = 4'($urandom_range(0, 15));
            d_f1 = 2'($urandom_range(0, 3)); d_f2 = 2'($urandom_range(0, 3));
            if (!m_alu_known && d_f1 == 2'd1) d_f1 = 2'd0;
            if (!m_alu_known && d_f2 == 2'd1) d_f2 = 2'd0;
            d_v = ($urandom_range(0, 9) != 0);
            d_st = ($urandom_range(0, 9) == 0);
            d_fl = ($urandom_range(0, 24) == 0);
            step();
        end

        // Park in stall so no further loads occur, then drain
        clr(); d_st = 1; step();
        repeat (3) @(negedge clk);
        chk("sb_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
